// File: rtl/sparse_hdc_pkg.sv
// rtl/sparse_hdc_pkg.sv - shared sizes and state type for the sparse HDC class search
//
// Purpose: geometry of the binarized class hypervector memory and the search
//          FSM state encoding, shared by hv_class_search and seg_popcount users.
package sparse_hdc_pkg;

    localparam int SEQ_CYCLE_COUNT = 10;
    localparam int NUM_CLASSES     = 26;
    localparam int SEG_W           = 1000;
    localparam int SCORE_W         = $clog2(SEG_W * SEQ_CYCLE_COUNT + 1);
    localparam int SEG_CNT_W       = $clog2(SEG_W + 1);
    localparam int SEG_CTR_W       = $clog2(SEQ_CYCLE_COUNT);
    localparam int CLASS_CTR_W     = $clog2(NUM_CLASSES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } search_state_t;

endpackage

// File: rtl/seg_popcount.sv
// rtl/seg_popcount.sv - combinational AND of two vectors followed by a popcount tree
//
// Purpose: overlap count popcount(i_a & i_b) between two binary segments.
// Ports:
//   i_a, i_b  in   W      operand segments
//   o_cnt     out  CNT_W  number of bit positions set in both operands
module seg_popcount #(
    parameter int W     = 1000,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    output logic [CNT_W-1:0] o_cnt
);

    // Pad the leaves to a power of two so every tree level halves cleanly;
    // the pad bits are zero so they never contribute to the count.
    localparam int LEVELS = $clog2(W);
    localparam int LEAVES = 1 << LEVELS;

    logic [W-1:0]      w_and;
    logic [LEAVES-1:0] w_pad;

    assign w_and = i_a & i_b;
    assign w_pad = LEAVES'(w_and);

    // Every partial sum is bounded by the total count, so CNT_W bits suffice
    // at every level of the tree.
    genvar l, n;
    generate
        for (l = 0; l <= LEVELS; l++) begin : g_lvl
            logic [CNT_W-1:0] w_sum [LEAVES >> l];
            for (n = 0; n < (LEAVES >> l); n++) begin : g_node
                if (l == 0) begin : g_leaf
                    assign w_sum[n] = CNT_W'(w_pad[n]);
                end else begin : g_add
                    assign w_sum[n] = g_lvl[l-1].w_sum[2*n] + g_lvl[l-1].w_sum[2*n+1];
                end
            end
        end
    endgenerate

    assign o_cnt = g_lvl[LEVELS].w_sum[0];

endmodule

// File: rtl/hv_class_search.sv
// rtl/hv_class_search.sv - arg-max search of query overlap over the binary class HV memory
//
// Purpose: after training, walks every class HV one segment per cycle,
//          accumulates popcount(query & class) per class and keeps the
//          strictly-greatest score (ties keep the lower class index).
// Ports:
//   clk, nrst        in   1          clock, async active-low reset
//   en               in   1          global enable, low freezes all state
//   start_search     in   1          level request to begin a search
//   class_gen_done   in   1          class memory valid, gates start_search
//   query_seg        in   SEG_W      query segment at seg_ctr
//   class_seg        in   SEG_W      class segment at {class_ctr, seg_ctr}
//   seg_ctr          out  4          segment select
//   class_ctr        out  5          class select
//   searching        out  1          search in progress
//   search_done      out  1          results valid
//   predicted_class  out  5          arg-max class index
//   best_score       out  SCORE_W    overlap of predicted_class
module hv_class_search
    import sparse_hdc_pkg::*;
(
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   en,
    input  logic                   start_search,
    input  logic                   class_gen_done,
    input  logic [SEG_W-1:0]       query_seg,
    input  logic [SEG_W-1:0]       class_seg,
    output logic [SEG_CTR_W-1:0]   seg_ctr,
    output logic [CLASS_CTR_W-1:0] class_ctr,
    output logic                   searching,
    output logic                   search_done,
    output logic [CLASS_CTR_W-1:0] predicted_class,
    output logic [SCORE_W-1:0]     best_score
);

    search_state_t          r_state;
    search_state_t          w_next_state;
    logic [SEG_CTR_W-1:0]   r_seg_ctr;
    logic [CLASS_CTR_W-1:0] r_class_ctr;
    logic [SCORE_W-1:0]     r_running_score;
    logic [SCORE_W-1:0]     r_best_score;
    logic [CLASS_CTR_W-1:0] r_predicted_class;

    logic [SEG_CNT_W-1:0]   w_seg_sum;
    logic [SCORE_W-1:0]     w_class_score;
    logic                   w_start;
    logic                   w_seg_last;
    logic                   w_class_last;

    seg_popcount #(
        .W     (SEG_W),
        .CNT_W (SEG_CNT_W)
    ) u_seg_popcount (
        .i_a   (query_seg),
        .i_b   (class_seg),
        .o_cnt (w_seg_sum)
    );

    assign w_start       = en && start_search && class_gen_done;
    assign w_seg_last    = (r_seg_ctr == SEG_CTR_W'(SEQ_CYCLE_COUNT - 1));
    assign w_class_last  = (r_class_ctr == CLASS_CTR_W'(NUM_CLASSES - 1));
    assign w_class_score = r_running_score + SCORE_W'(w_seg_sum);

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; en low holds the current state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next_state = S_SEARCH;
            S_SEARCH: if (en && w_seg_last && w_class_last) w_next_state = S_DONE;
            S_DONE:   if (w_start) w_next_state = S_SEARCH;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        searching   = 1'b0;
        search_done = 1'b0;
        case (r_state)
            S_SEARCH: searching   = 1'b1;
            S_DONE:   search_done = 1'b1;
            default:  ;
        endcase
    end

    // Counters, per-class accumulator and arg-max registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_seg_ctr         <= '0;
            r_class_ctr       <= '0;
            r_running_score   <= '0;
            r_best_score      <= '0;
            r_predicted_class <= '0;
        end else if (en) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_seg_ctr         <= '0;
                        r_class_ctr       <= '0;
                        r_running_score   <= '0;
                        r_best_score      <= '0;
                        r_predicted_class <= '0;
                    end
                end
                S_SEARCH: begin
                    if (w_seg_last) begin
                        // Class complete: fold into the arg-max and move on.
                        // Strict compare keeps the earlier class on ties.
                        r_seg_ctr       <= '0;
                        r_running_score <= '0;
                        r_class_ctr     <= w_class_last ? '0 : r_class_ctr + CLASS_CTR_W'(1);
                        if (w_class_score > r_best_score) begin
                            r_best_score      <= w_class_score;
                            r_predicted_class <= r_class_ctr;
                        end
                    end else begin
                        r_seg_ctr       <= r_seg_ctr + SEG_CTR_W'(1);
                        r_running_score <= w_class_score;
                    end
                end
                default: ;
            endcase
        end
    end

    assign seg_ctr         = r_seg_ctr;
    assign class_ctr       = r_class_ctr;
    assign predicted_class = r_predicted_class;
    assign best_score      = r_best_score;

endmodule

// File: tb/tb_hv_class_search.sv
// tb/tb_hv_class_search.sv - scoreboard bench for hv_class_search
module tb_hv_class_search;
    import sparse_hdc_pkg::*;

    localparam int NSEARCH = NUM_CLASSES * SEQ_CYCLE_COUNT;

    logic                   clk = 1'b0;
    logic                   nrst = 1'b0;
    logic                   en = 1'b1;
    logic                   start_search = 1'b0;
    logic                   class_gen_done = 1'b0;
    logic [SEG_W-1:0]       query_seg;
    logic [SEG_W-1:0]       class_seg;
    logic [SEG_CTR_W-1:0]   seg_ctr;
    logic [CLASS_CTR_W-1:0] class_ctr;
    logic                   searching;
    logic                   search_done;
    logic [CLASS_CTR_W-1:0] predicted_class;
    logic [SCORE_W-1:0]     best_score;

    logic [SEG_W-1:0] qmem [SEQ_CYCLE_COUNT];
    logic [SEG_W-1:0] cmem [NUM_CLASSES][SEQ_CYCLE_COUNT];

    typedef struct {
        int pred;
        int score;
        int cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign query_seg = (seg_ctr < SEQ_CYCLE_COUNT) ? qmem[seg_ctr] : '0;
    assign class_seg = (class_ctr < NUM_CLASSES && seg_ctr < SEQ_CYCLE_COUNT) ?
                       cmem[class_ctr][seg_ctr] : '0;

    hv_class_search dut (
        .clk             (clk),
        .nrst            (nrst),
        .en              (en),
        .start_search    (start_search),
        .class_gen_done  (class_gen_done),
        .query_seg       (query_seg),
        .class_seg       (class_seg),
        .seg_ctr         (seg_ctr),
        .class_ctr       (class_ctr),
        .searching       (searching),
        .search_done     (search_done),
        .predicted_class (predicted_class),
        .best_score      (best_score)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: whole-HV overlap per class, first strictly-greatest wins.
    task automatic push_expected(input int cycles);
        exp_t e;
        int   s;
        e.pred = 0;
        e.score = 0;
        e.cycles = cycles;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            s = 0;
            for (int g = 0; g < SEQ_CYCLE_COUNT; g++)
                s += $countones(qmem[g] & cmem[c][g]);
            if (s > e.score) begin
                e.score = s;
                e.pred = c;
            end
        end
        exp_q.push_back(e);
    endtask

    function automatic logic [SEG_W-1:0] rand_seg(input int one_in);
        logic [SEG_W-1:0] v;
        for (int i = 0; i < SEG_W; i++)
            v[i] = ($urandom_range(0, one_in - 1) == 0);
        return v;
    endfunction

    task automatic fill_random(input int q_one_in, input int c_one_in);
        for (int g = 0; g < SEQ_CYCLE_COUNT; g++) begin
            qmem[g] = rand_seg(q_one_in);
            for (int c = 0; c < NUM_CLASSES; c++)
                cmem[c][g] = rand_seg(c_one_in);
        end
    endtask

    task automatic clear_mem();
        for (int g = 0; g < SEQ_CYCLE_COUNT; g++) begin
            qmem[g] = '0;
            for (int c = 0; c < NUM_CLASSES; c++)
                cmem[c][g] = '0;
        end
    endtask

    task automatic issue_start(input int cycles);
        @(posedge clk); #1;
        start_search = 1'b1;
        push_expected(cycles);
        @(posedge clk); #1;
        start_search = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!search_done && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (!search_done) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_ctr(input int cls, input int seg);
        int n = 0;
        while (!(class_ctr == cls && seg_ctr == seg) && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_ctr", (class_ctr == cls && seg_ctr == seg) ? 1 : 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_seg_ctr"}, int'(seg_ctr), 0);
        chk({tag, "_class_ctr"}, int'(class_ctr), 0);
        chk({tag, "_searching"}, int'(searching), 0);
        chk({tag, "_done"}, int'(search_done), 0);
        chk({tag, "_pred"}, int'(predicted_class), 0);
        chk({tag, "_score"}, int'(best_score), 0);
    endtask

    // Monitor: counts S_SEARCH cycles, compares results on each done rise.
    logic prev_done = 1'b0;
    logic prev_srch = 1'b0;
    int   srch_cnt  = 0;
    always @(negedge clk) begin
        if (!nrst) begin
            prev_done = 1'b0;
            prev_srch = 1'b0;
            srch_cnt  = 0;
        end else begin
            if (searching)
                srch_cnt = prev_srch ? srch_cnt + 1 : 1;
            if (search_done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("predicted_class", int'(predicted_class), e.pred);
                    chk("best_score", int'(best_score), e.score);
                    chk("search_cycles", srch_cnt, e.cycles);
                end
            end
            prev_done = search_done;
            prev_srch = searching;
        end
    end

    initial begin
        clear_mem();
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        nrst = 1'b1;

        // start without class_gen_done is ignored
        start_search = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk_all_zero("idle_gated");
        end
        start_search = 1'b0;
        class_gen_done = 1'b1;

        // single winner
        for (int g = 0; g < SEQ_CYCLE_COUNT; g++) begin
            qmem[g] = '1;
            cmem[7][g] = '1;
        end
        issue_start(NSEARCH);
        wait_done();

        // tie between classes 3 and 12 at 50; others below 50
        clear_mem();
        for (int g = 0; g < SEQ_CYCLE_COUNT; g++) qmem[g] = '1;
        for (int i = 0; i < 50; i++) begin
            cmem[3][i % SEQ_CYCLE_COUNT][i * 7] = 1'b1;
            cmem[12][0][i] = 1'b1;
        end
        for (int c = 0; c < NUM_CLASSES; c++)
            if (c != 3 && c != 12)
                for (int i = 0; i < int'($urandom_range(0, 49)); i++)
                    cmem[c][i % SEQ_CYCLE_COUNT][i] = 1'b1;
        issue_start(NSEARCH);
        wait_done();

        // random memories
        for (int r = 0; r < 3; r++) begin
            fill_random(2 + r, 8);
            issue_start(NSEARCH);
            wait_done();
        end

        // enable stall at class 10, segment 4
        fill_random(3, 6);
        issue_start(NSEARCH + 5);
        wait_ctr(10, 4);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_class", int'(class_ctr), 10);
            chk("stall_seg", int'(seg_ctr), 4);
            chk("stall_searching", int'(searching), 1);
        end
        en = 1'b1;
        wait_done();

        // async reset mid-search at class 15
        fill_random(2, 5);
        issue_start(NSEARCH);
        wait_ctr(15, 0);
        #3;
        nrst = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk_all_zero("async_rst");
        @(posedge clk); #1;
        nrst = 1'b1;
        issue_start(NSEARCH);
        wait_done();

        // back-to-back restart from S_DONE: class 25 best with score 1
        @(posedge clk); #1;
        chk("done_hold", int'(search_done), 1);
        clear_mem();
        qmem[6][123] = 1'b1;
        cmem[25][6][123] = 1'b1;
        cmem[4][6][124] = 1'b1;
        issue_start(NSEARCH);
        chk("b2b_searching", int'(searching), 1);
        chk("b2b_clear_pred", int'(predicted_class), 0);
        chk("b2b_clear_score", int'(best_score), 0);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
